// File: rtl/svm_det_fifo_if.sv
// Classifier-result input stream and detection readout stream of svm_det_fifo.
// master: the detection queue (consumes classifier results, drives the head); slave: the far side.
interface svm_det_fifo_if #(
  parameter int SW_W = 11,
  parameter int X_W  = 6,
  parameter int Y_W  = 5
) ();

  logic            i_valid;
  logic            is_person;
  logic [SW_W-1:0] sw_id;

  logic            o_valid;
  logic            o_ready;
  logic [X_W-1:0]  o_x;
  logic [Y_W-1:0]  o_y;
  logic [X_W-1:0]  o_len;

  modport master (
    input  i_valid, is_person, sw_id, o_ready,
    output o_valid, o_x, o_y, o_len
  );

  modport slave (
    output i_valid, is_person, sw_id, o_ready,
    input  o_valid, o_x, o_y, o_len
  );

endinterface

// File: rtl/svm_det_fifo.sv
// Detection queue behind the SVM classifier: window index -> (col,row), sequence check, per-frame count, FIFO readout.
// Optional horizontal run merge of positive windows when SVM_DET_FIFO_NMS_EN is defined.
module svm_det_fifo #(
  parameter int SW_W    = 11,
  parameter int SW_COLS = 34,
  parameter int SW_ROWS = 16,
  parameter int X_W     = 6,
  parameter int Y_W     = 5,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  svm_det_fifo_if.master    bus,
  input  logic              clr_err,
  output logic              frame_done,
  output logic [CNT_W-1:0]  det_cnt,
  output logic              ovf,
  output logic              seq_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int E_W = X_W + Y_W + X_W;

  localparam logic [X_W-1:0]   COL_LAST = X_W'(SW_COLS - 1);
  localparam logic [Y_W-1:0]   ROW_LAST = Y_W'(SW_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    ST_RUN,
    ST_SKIP
  } state_t;

  state_t state_reg, state_next;

  logic [X_W-1:0]   col_reg;
  logic [Y_W-1:0]   row_reg;
  logic [SW_W-1:0]  exp_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] det_cnt_reg;
  logic             frame_done_reg;
  logic             ovf_reg;
  logic             seq_err_reg;

  logic             id_match;
  logic             id_zero;
  logic             acc;
  logic             restart;
  logic             mismatch;

  logic [X_W-1:0]   pos_col;
  logic [Y_W-1:0]   pos_row;
  logic [SW_W-1:0]  pos_id;
  logic             eol;
  logic             last;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_sum;

  logic             det_inc;
  logic             push_v;
  logic [E_W-1:0]   push_e;

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;
  logic [E_W-1:0]   rd_arr [DEPTH];
  logic [E_W-1:0]   head;

  assign id_match = (bus.sw_id == exp_reg);
  assign id_zero  = (bus.sw_id == '0);

  // ---------------------------------------------------------------
  // Sequence FSM: RUN tracks the index stream; SKIP drops windows until
  // index 0 reappears, because a mid-frame position cannot be rebuilt
  // without a divider.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc        = 1'b0;
    restart    = 1'b0;
    mismatch   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (bus.i_valid) begin
          if (id_match) begin
            acc = 1'b1;
          end else begin
            mismatch = 1'b1;
            if (id_zero) begin
              acc     = 1'b1;
              restart = 1'b1;
            end else begin
              state_next = ST_SKIP;
            end
          end
        end
      end
      ST_SKIP: begin
        if (bus.i_valid && id_zero) begin
          acc        = 1'b1;
          restart    = 1'b1;
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------
  // Position of the window being accepted this cycle
  // ---------------------------------------------------------------
  always_comb begin
    pos_col  = restart ? '0 : col_reg;
    pos_row  = restart ? '0 : row_reg;
    pos_id   = restart ? '0 : exp_reg;
    cnt_base = restart ? '0 : cnt_reg;
    eol      = (pos_col == COL_LAST);
    last     = eol && (pos_row == ROW_LAST);
    cnt_sum  = cnt_base;
    if (det_inc && (cnt_base != CNT_MAX)) begin
      cnt_sum = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      exp_reg        <= '0;
      cnt_reg        <= '0;
      det_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= acc && last;
      if (acc) begin
        if (eol) begin
          col_reg <= '0;
          row_reg <= last ? '0 : pos_row + 1'b1;
        end else begin
          col_reg <= pos_col + 1'b1;
          row_reg <= pos_row;
        end
        exp_reg <= last ? '0 : pos_id + 1'b1;
        if (last) begin
          det_cnt_reg <= cnt_sum;
          cnt_reg     <= '0;
        end else begin
          cnt_reg     <= cnt_sum;
        end
      end
    end
  end

`ifdef SVM_DET_FIFO_NMS_EN
  // ---------------------------------------------------------------
  // Run merge: positives extend a pending run; a negative window or the
  // row end closes it, and the closed run is pushed on the next cycle.
  // ---------------------------------------------------------------
  logic           pend_v_reg;
  logic [X_W-1:0] pend_x_reg;
  logic [Y_W-1:0] pend_y_reg;
  logic [X_W-1:0] pend_len_reg;
  logic           flush_v_reg;
  logic [E_W-1:0] flush_e_reg;

  logic           pend_live;
  logic [X_W-1:0] run_x;
  logic [X_W-1:0] run_len;
  logic           flush;
  logic [E_W-1:0] flush_e;
  logic           pend_set;

  always_comb begin
    // A sequence break abandons the run; its windows are untrustworthy.
    pend_live = pend_v_reg && !mismatch;
    run_x     = pend_live ? pend_x_reg : pos_col;
    run_len   = pend_live ? pend_len_reg + 1'b1 : X_W'(1);
    flush     = acc && ((bus.is_person && eol) || (!bus.is_person && pend_live));
    flush_e   = bus.is_person ? {run_x, pos_row, run_len}
                              : {pend_x_reg, pend_y_reg, pend_len_reg};
    pend_set  = acc && bus.is_person && !eol;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_reg   <= 1'b0;
      pend_x_reg   <= '0;
      pend_y_reg   <= '0;
      pend_len_reg <= '0;
      flush_v_reg  <= 1'b0;
      flush_e_reg  <= '0;
    end else begin
      if (pend_set) begin
        pend_v_reg   <= 1'b1;
        pend_x_reg   <= run_x;
        pend_y_reg   <= pos_row;
        pend_len_reg <= run_len;
      end else if (acc || mismatch) begin
        pend_v_reg   <= 1'b0;
      end
      flush_v_reg <= flush;
      if (flush) begin
        flush_e_reg <= flush_e;
      end
    end
  end

  assign det_inc = flush;
  assign push_v  = flush_v_reg;
  assign push_e  = flush_e_reg;
`else
  assign det_inc = acc && bus.is_person;
  assign push_v  = det_inc;
  assign push_e  = {pos_col, pos_row, X_W'(1)};
`endif

  // ---------------------------------------------------------------
  // FIFO: pointers carry an extra wrap bit so full and empty differ
  // ---------------------------------------------------------------
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop   = !empty && bus.o_ready;
  assign wr_en = push_v && (!full || pop);
  assign drop  = push_v && full && !pop;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [E_W-1:0] ent_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ent_reg <= '0;
        end else if (wr_en && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          ent_reg <= push_e;
        end
      end

      assign rd_arr[gi] = ent_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  assign head = rd_arr[rd_ptr_reg[AW-1:0]];

  // ---------------------------------------------------------------
  // Sticky error flags: a new event outranks a simultaneous clear
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg     <= 1'b0;
      seq_err_reg <= 1'b0;
    end else begin
      ovf_reg     <= drop     || (ovf_reg     && !clr_err);
      seq_err_reg <= mismatch || (seq_err_reg && !clr_err);
    end
  end

  assign bus.o_valid = !empty;
  assign bus.o_x     = head[E_W-1 -: X_W];
  assign bus.o_y     = head[X_W +: Y_W];
  assign bus.o_len   = head[X_W-1:0];

  assign frame_done  = frame_done_reg;
  assign det_cnt     = det_cnt_reg;
  assign ovf         = ovf_reg;
  assign seq_err     = seq_err_reg;

endmodule

// File: tb/tb_svm_det_fifo.sv
// Directed bench for svm_det_fifo: frame mapping, stall/overflow, sequence resync, push/pop at full, reset, row split.
module tb_svm_det_fifo;

  localparam int SW_W  = 11;
  localparam int X_W   = 6;
  localparam int Y_W   = 5;
  localparam int CNT_W = 10;
`ifdef SVM_DET_FIFO_NMS_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr_err = 1'b0;
  logic             frame_done;
  logic [CNT_W-1:0] det_cnt;
  logic             ovf;
  logic             seq_err;

  svm_det_fifo_if #(.SW_W(SW_W), .X_W(X_W), .Y_W(Y_W)) bus ();

  svm_det_fifo #(
    .SW_W(SW_W), .SW_COLS(34), .SW_ROWS(16), .X_W(X_W), .Y_W(Y_W), .DEPTH(16), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_err   (clr_err),
    .frame_done(frame_done),
    .det_cnt   (det_cnt),
    .ovf       (ovf),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];

  // Popped entries and frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && bus.o_ready) got_q.push_back({bus.o_x, bus.o_y, bus.o_len});
      if (frame_done) fd_cnt++;
    end
  end

  function automatic logic [16:0] ent(input int x, input int y, input int l);
    return {X_W'(x), Y_W'(y), X_W'(l)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic send(input int id, input bit p);
    bus.i_valid   = 1'b1;
    bus.sw_id     = SW_W'(id);
    bus.is_person = p;
    @(posedge clk);
    #1;
    bus.i_valid   = 1'b0;
    bus.is_person = 1'b0;
  endtask

  // n isolated detections in row 0 starting at column 'start'
  task automatic push_n(input int start, input int n);
    for (int k = 0; k < n; k++) begin
      send(start + k * STEP, 1'b1);
      if (STEP == 2) send(start + k * STEP + 1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_q(input string tag);
    int n = exp_q.size();
    for (int c = 0; c < 60 && got_q.size() < n; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got_q.size()) check($sformatf("%s_%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid   = 1'b0;
    bus.is_person = 1'b0;
    bus.sw_id     = '0;
    bus.o_ready   = 1'b0;
    #2;
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_det_cnt", det_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_head", {bus.o_x, bus.o_y, bus.o_len}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full frame, positives at 0, 35, 543
    bus.o_ready = 1'b1;
    got_q.delete();
    fd_cnt = 0;
    for (int id = 0; id < 544; id++) begin
      send(id, (id == 0) || (id == 35) || (id == 543));
      if (id == 542) check("fd_before_last", frame_done, 0);
    end
    check("fd_pulse", frame_done, 1);
    check("frame_det_cnt", det_cnt, 3);
    @(posedge clk);
    #1;
    check("fd_cleared", frame_done, 0);
    exp_q.push_back(ent(0, 0, 1));
    exp_q.push_back(ent(1, 1, 1));
    exp_q.push_back(ent(33, 15, 1));
    check_q("frame");
    check("fd_pulses", fd_cnt, 1);

    // Reset mid-frame with entries queued
    bus.o_ready = 1'b0;
    for (int id = 0; id <= 200; id++) send(id, (id == 10) || (id == 50) || (id == 100));
    @(posedge clk);
    #1;
    check("pre_rst_valid", bus.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", bus.o_valid, 0);
    check("rst_mid_det_cnt", det_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    bus.o_ready = 1'b1;
    send(0, 1'b1);
    send(1, 1'b0);
    exp_q.push_back(ent(0, 0, 1));
    check_q("post_rst");
    check("post_rst_seq_err", seq_err, 0);

    // Stall: 17 detections into a 16-deep FIFO
    do_reset();
    bus.o_ready = 1'b0;
    got_q.delete();
    push_n(0, 17);
    @(posedge clk);
    #1;
    check("stall_ovf", ovf, 1);
    check("stall_valid", bus.o_valid, 1);
    check("stall_head", {bus.o_x, bus.o_y, bus.o_len}, ent(0, 0, 1));
    repeat (3) @(posedge clk);
    #1;
    check("stall_head_hold", {bus.o_x, bus.o_y, bus.o_len}, ent(0, 0, 1));
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("ovf_cleared", ovf, 0);
    bus.o_ready = 1'b1;
    for (int k = 0; k < 16; k++) exp_q.push_back(ent(k * STEP, 0, 1));
    check_q("stall");

    // Push and pop together while full
    do_reset();
    bus.o_ready = 1'b0;
    got_q.delete();
    push_n(0, 16);
    @(posedge clk);
    #1;
    check("full_no_ovf", ovf, 0);
    bus.o_ready = 1'b1;
    push_n(16 * STEP, 1);
    @(posedge clk);
    #1;
    check("pushpop_ovf", ovf, 0);
    for (int k = 0; k < 17; k++) exp_q.push_back(ent(k * STEP, 0, 1));
    check_q("pushpop");

    // Sequence jump and resync on index 0
    do_reset();
    bus.o_ready = 1'b1;
    got_q.delete();
    send(0, 1'b0);
    send(1, 1'b1);
    send(2, 1'b0);
    check("seq_ok", seq_err, 0);
    send(7, 1'b1);
    check("seq_jump", seq_err, 1);
    send(3, 1'b1);
    send(0, 1'b1);
    send(1, 1'b1);
    send(2, 1'b0);
    exp_q.push_back(ent(1, 0, 1));
`ifdef SVM_DET_FIFO_NMS_EN
    exp_q.push_back(ent(0, 0, 2));
`else
    exp_q.push_back(ent(0, 0, 1));
    exp_q.push_back(ent(1, 0, 1));
`endif
    check_q("seq");
    check("seq_sticky", seq_err, 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    check("seq_cleared", seq_err, 0);
    clr_err = 1'b1;
    send(9, 1'b0);
    clr_err = 1'b0;
    check("set_wins", seq_err, 1);

    // Run crossing a row boundary
    do_reset();
    bus.o_ready = 1'b1;
    got_q.delete();
    for (int id = 0; id <= 37; id++) send(id, (id >= 33) && (id <= 36));
    exp_q.push_back(ent(33, 0, 1));
`ifdef SVM_DET_FIFO_NMS_EN
    exp_q.push_back(ent(0, 1, 3));
`else
    exp_q.push_back(ent(0, 1, 1));
    exp_q.push_back(ent(1, 1, 1));
    exp_q.push_back(ent(2, 1, 1));
`endif
    check_q("row_split");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_det_fifo.md
Name: svm_det_fifo

Overview:
- Downstream of the SVM classifier. Consumes the per-window `is_person` / `o_valid` / `sw_id` stream.
- Converts window indices to (col,row) coordinates, checks index sequence, counts detections per frame.
- Queues positive detections in a small FIFO with valid/ready readout toward the host/overlay stage.

Parameters:
- SW_W, 11, slide-window index width (matches classifier)
- SW_COLS, 34, windows per row
- SW_ROWS, 16, window rows per frame (SW_COLS*SW_ROWS <= 2**SW_W)
- X_W, 6, column coordinate width (>= clog2(SW_COLS))
- Y_W, 5, row coordinate width (>= clog2(SW_ROWS))
- DEPTH, 16, FIFO entries, power of two
- CNT_W, 10, per-frame detection counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_valid  in  1  classifier result valid
- is_person  in  1  classifier decision
- sw_id  in  SW_W  classifier window index
- clr_err  in  1  clears sticky error flags
- o_valid  out  1  FIFO head valid
- o_ready  in  1  consumer accepts head
- o_x  out  X_W  head column
- o_y  out  Y_W  head row
- o_len  out  X_W  head run length (always 1 without DET_NMS_EN)
- frame_done  out  1  one-cycle pulse after last window of frame
- det_cnt  out  CNT_W  detections in last completed frame
- ovf  out  1  sticky: detection dropped, FIFO full
- seq_err  out  1  sticky: sw_id differed from expected

Behaviour:
- Clock and reset: single clock `clk`, reset `rst` asynchronous active-high. All registers clear on `rst`.
- Outputs in reset: `o_valid`, `frame_done`, `ovf` and `seq_err` = 0; `det_cnt`, `o_x`, `o_y` and `o_len` = 0.
- Position counters `col` (0..SW_COLS-1) and `row` (0..SW_ROWS-1):
  - Advance by one on each `i_valid`; `col` wraps to 0 and increments `row`.
  - At `col`=SW_COLS-1 and `row`=SW_ROWS-1 both wrap to 0 (end of frame).
  - Expected index = `row`*SW_COLS + `col`, held as a separate incrementing register (no multiplier).
- Sequence check:
  - On `i_valid` with `sw_id` != expected: set `seq_err`, then resync.
  - Resync: expected <= `sw_id`+1; `col`/`row` are recomputed by a restart. If `sw_id`==0, position is (0,0). Otherwise the counters are loaded from a small quotient/remainder walk is NOT used; instead the classifier output is ignored until `sw_id`==0 arrives.
  - While ignoring, `frame_done` is not pulsed.
- Detection capture, no merge:
  - `i_valid` & `is_person` pushes {`col`,`row`,1}.
  - Entry is visible at `o_valid` no earlier than the next cycle (1-cycle latency when FIFO empty).
- FIFO:
  - Registered read/write pointers, one extra wrap bit; full/empty derived from the pointers.
  - Pop when `o_valid` & `o_ready`.
  - Push and pop in the same cycle: allowed when full (the pop frees the slot) and when empty (the entry appears next cycle).
  - Push while full without a pop: entry dropped, `ovf` set.
  - `o_x`/`o_y`/`o_len` are the head entry and hold stable while `o_valid` & !`o_ready`.
- Frame counter:
  - Increments per accepted detection (dropped detections still counted), saturating at 2**CNT_W-1.
  - At the last window: `det_cnt` <= final count (including a detection in that same window), counter <= 0, `frame_done` pulses one cycle later.
- Error flags: `clr_err` clears `ovf` and `seq_err`. If a set and `clr_err` coincide, set wins.
- `rst` mid-frame: FIFO emptied, counters to 0; the next window is treated as index 0.

Optional Feature:
- Macro: `SVM_DET_FIFO_NMS_EN`.
- Defined (horizontal run merge):
  - A run of consecutive positive windows in one row is held in a pending register (start `col`, `row`, length) and pushed as one entry.
  - The entry is pushed when the run ends: a negative window, end of row, or end of frame.
  - Push occurs the cycle after the terminating `i_valid`.
  - `det_cnt` counts entries, not windows.
  - `rst` discards the pending run.
- Undefined: every positive window is a separate entry, `o_len`=1, and no pending register exists.

Test Plan:
- Full frame of 544 windows, positives at ids 0, 35 and 543, `o_ready`=1 → entries (0,0), (1,1), (33,15); `det_cnt`=3; `frame_done` one pulse after id 543.
- Stall: `o_ready`=0, 17 consecutive positives at ids 0-16 → FIFO holds ids 0-15, `ovf`=1, head (0,0) stable; `clr_err` → `ovf`=0.
- Sequence jump: ids 0,1,2 then 7 → `seq_err`=1; output ignored until id 0 reappears, then normal capture resumes.
- Simultaneous push/pop at full with `o_ready`=1 → no drop, `ovf` stays 0, entry order preserved.
- `rst` asserted mid-frame (after id 200, 3 entries queued) → `o_valid`=0 immediately, `det_cnt`=0; next id 0 is accepted.
- NMS_EN: positives at ids 33, 34, 35, 36 → entries (33,0,len1) and (0,1,len3) — the run is split at the row end. Without the macro: 4 entries, each len1.
